// File: rtl/silent_stepper_seq.sv
// ============================================================================
// Module  : silent_stepper_seq
// Brief   : Time-multiplexed duty/phase slew limiter. One channel per clock
//           through a 2-stage pipeline. Define SILENT_PHASE_WRAP_EN for
//           shortest-path modulo-CYCLE phase slewing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module silent_stepper_seq #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_update,
    input  logic [WIDTH-1:0] i_step_duty,
    input  logic [WIDTH-1:0] i_step_phase,
    input  logic [WIDTH-1:0] i_cycle   [DEPTH],
    input  logic [WIDTH-1:0] i_duty    [DEPTH],
    input  logic [WIDTH-1:0] i_phase   [DEPTH],
    output logic [WIDTH-1:0] o_duty_s  [DEPTH],
    output logic [WIDTH-1:0] o_phase_s [DEPTH],
    output logic             o_busy,
    output logic             o_out_valid
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = WIDTH + 3;
    localparam logic [IW-1:0] c_LAST = IW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef SILENT_PHASE_WRAP_EN
    localparam logic c_WRAP = 1'b1;
`else
    localparam logic c_WRAP = 1'b0;
`endif

    // Bounded step toward target; with wrap, the difference is folded into
    // (-cyc/2, cyc/2] and the result reduced back into 0..cyc-1.
    function automatic logic [WIDTH-1:0] f_slew(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] step,
        input logic [WIDTH-1:0] cyc,
        input logic             wrap
    );
        logic signed [SW-1:0] d;
        logic signed [SW-1:0] c;
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] n;
        c = $signed({3'b000, cyc});
        s = $signed({3'b000, step});
        d = $signed({3'b000, tgt}) - $signed({3'b000, cur});
        if (wrap) begin
            if ((d <<< 1) > c) begin
                d = d - c;
            end else if ((d <<< 1) <= -c) begin
                d = d + c;
            end
        end
        if (((d >= 0) && (d <= s)) || ((d < 0) && (-d <= s))) begin
            n = $signed({3'b000, tgt});
        end else if (d > 0) begin
            n = $signed({3'b000, cur}) + s;
        end else begin
            n = $signed({3'b000, cur}) - s;
        end
        if (wrap) begin
            if (n < 0) begin
                n = n + c;
            end else if (n >= c) begin
                n = n - c;
            end
        end
        return n[WIDTH-1:0];
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_start;
    logic             r_busy;
    logic             r_pending;
    logic             r_en;
    logic [WIDTH-1:0] r_step_d;
    logic [WIDTH-1:0] r_step_p;
    logic             r_rd_active;
    logic [IW-1:0]    r_rd_idx;
    logic             r_last_wr;

    logic             r_s1_valid;
    logic [IW-1:0]    r_s1_idx;
    logic [WIDTH-1:0] r_s1_cyc;
    logic [WIDTH-1:0] r_s1_tgt_d;
    logic [WIDTH-1:0] r_s1_tgt_p;
    logic [WIDTH-1:0] r_s1_cur_d;
    logic [WIDTH-1:0] r_s1_cur_p;

    logic [WIDTH-1:0] r_duty_s  [DEPTH];
    logic [WIDTH-1:0] r_phase_s [DEPTH];
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] w_phase_nxt;

    assign w_start = (r_state == S_IDLE) && (i_update || r_pending);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_update || r_pending) w_state_nxt = S_RUN;
            S_RUN:   if (r_last_wr) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer: read pointer feeds stage 1; stage 2 writes the channel back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_pending   <= 1'b0;
            r_en        <= 1'b0;
            r_step_d    <= '0;
            r_step_p    <= '0;
            r_rd_active <= 1'b0;
            r_rd_idx    <= '0;
            r_last_wr   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_cyc    <= '0;
            r_s1_tgt_d  <= '0;
            r_s1_tgt_p  <= '0;
            r_s1_cur_d  <= '0;
            r_s1_cur_p  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);

            if (w_start) begin
                r_pending <= 1'b0;
            end else if (i_update && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (w_start) begin
                r_en        <= i_enable;
                r_step_d    <= i_step_duty;
                r_step_p    <= i_step_phase;
                r_rd_active <= 1'b1;
                r_rd_idx    <= '0;
            end else if (r_rd_active) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (r_rd_idx == c_LAST) begin
                    r_rd_active <= 1'b0;
                end
            end

            r_s1_valid <= r_rd_active;
            if (r_rd_active) begin
                r_s1_idx   <= r_rd_idx;
                r_s1_cyc   <= i_cycle[r_rd_idx];
                r_s1_tgt_d <= i_duty[r_rd_idx];
                r_s1_tgt_p <= i_phase[r_rd_idx];
                r_s1_cur_d <= r_duty_s[r_rd_idx];
                r_s1_cur_p <= r_phase_s[r_rd_idx];
            end

            r_last_wr <= r_s1_valid && (r_s1_idx == c_LAST);
        end
    end

    always_comb begin
        w_duty_nxt  = '0;
        w_phase_nxt = '0;
        if (r_s1_cyc == '0) begin
            w_duty_nxt  = '0;
            w_phase_nxt = '0;
        end else if (!r_en) begin
            w_duty_nxt  = r_s1_tgt_d;
            w_phase_nxt = r_s1_tgt_p;
        end else begin
            w_duty_nxt  = f_slew(r_s1_cur_d, r_s1_tgt_d, r_step_d, r_s1_cyc, 1'b0);
            w_phase_nxt = f_slew(r_s1_cur_p, r_s1_tgt_p, r_step_p, r_s1_cyc, c_WRAP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_duty_s[i]  <= '0;
                r_phase_s[i] <= '0;
            end
        end else if (r_s1_valid) begin
            r_duty_s[r_s1_idx]  <= w_duty_nxt;
            r_phase_s[r_s1_idx] <= w_phase_nxt;
        end
    end

    assign o_duty_s    = r_duty_s;
    assign o_phase_s   = r_phase_s;
    assign o_busy      = r_busy;
    assign o_out_valid = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_silent_stepper_seq.sv
// ============================================================================
// Module  : tb_silent_stepper_seq
// Brief   : Directed + randomized self-checking bench for silent_stepper_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_silent_stepper_seq;

    localparam int W = 13;
    localparam int D = 4;

`ifdef SILENT_PHASE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         enable;
    logic         update;
    logic [W-1:0] step_d;
    logic [W-1:0] step_p;
    logic [W-1:0] cyc   [D];
    logic [W-1:0] duty  [D];
    logic [W-1:0] phase [D];
    logic [W-1:0] dso   [D];
    logic [W-1:0] pso   [D];
    logic         busy;
    logic         ov;

    int n_tests = 0;
    int n_fail  = 0;
    int m_d [D];
    int m_p [D];

    silent_stepper_seq #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (enable),
        .i_update     (update),
        .i_step_duty  (step_d),
        .i_step_phase (step_p),
        .i_cycle      (cyc),
        .i_duty       (duty),
        .i_phase      (phase),
        .o_duty_s     (dso),
        .o_phase_s    (pso),
        .o_busy       (busy),
        .o_out_valid  (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: move toward target by at most step; wrap picks the short way round.
    function automatic int slew(int cur, int tgt, int step, int c, bit wrap);
        int d;
        int n;
        d = tgt - cur;
        if (wrap) begin
            if (2 * d > c) d = d - c;
            else if (2 * d <= -c) d = d + c;
        end
        if (d <= step && d >= -step) n = tgt;
        else if (d > 0) n = cur + step;
        else n = cur - step;
        if (wrap) n = ((n % c) + c) % c;
        return n;
    endfunction

    task automatic model_sweep();
        for (int i = 0; i < D; i++) begin
            if (cyc[i] == 0) begin
                m_d[i] = 0;
                m_p[i] = 0;
            end else if (!enable) begin
                m_d[i] = duty[i];
                m_p[i] = phase[i];
            end else begin
                m_d[i] = slew(m_d[i], duty[i], step_d, cyc[i], 1'b0);
                m_p[i] = slew(m_p[i], phase[i], step_p, cyc[i], WRAP);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("%s_duty%0d", tag, i), 32'(dso[i]), 32'(m_d[i]));
            chk($sformatf("%s_phase%0d", tag, i), 32'(pso[i]), 32'(m_p[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        update = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D; i++) begin
            m_d[i] = 0;
            m_p[i] = 0;
        end
    endtask

    // One UPDATE pulse, wait (bounded) for OUT_VALID, then advance the model.
    task automatic run_sweep();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        for (int k = 0; k < 40 && !ov; k++) @(negedge clk);
        chk("sweep_done", 32'(ov), 32'd1);
        model_sweep();
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ov) n++;
        end
    endtask

    int npulse;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        update = 1'b0;
        step_d = '0;
        step_p = '0;
        for (int i = 0; i < D; i++) begin
            cyc[i] = 13'd4096;
            duty[i] = '0;
            phase[i] = '0;
        end

        // Reset state, and no OUT_VALID without UPDATE
        do_reset();
        check_all("reset");
        chk("reset_busy", 32'(busy), 32'd0);
        count_pulses(12, npulse);
        chk("idle_no_ov", 32'(npulse), 32'd0);

        // Duty steps 10, 20, 25, then stable
        step_d = 13'd10;
        duty[0] = 13'd25;
        run_sweep();
        chk("step1", 32'(dso[0]), 32'd10);
        run_sweep();
        chk("step2", 32'(dso[0]), 32'd20);
        run_sweep();
        chk("step3", 32'(dso[0]), 32'd25);
        run_sweep();
        chk("step4", 32'(dso[0]), 32'd25);
        check_all("steps");

        // Per-cycle timing of BUSY, OUT_VALID and channel write order
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < D; i++) duty[i] = W'(100 + 7 * i);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        for (int k = 0; k <= D + 3; k++) begin
            chk($sformatf("tim_busy_k%0d", k), 32'(busy), 32'((k >= 1 && k <= D + 2) ? 1 : 0));
            chk($sformatf("tim_ov_k%0d", k), 32'(ov), 32'((k == D + 2) ? 1 : 0));
            for (int i = 0; i < D; i++)
                chk($sformatf("tim_ch%0d_k%0d", i, k), 32'(dso[i]),
                    32'((k >= 2 + i) ? duty[i] : m_d[i]));
            @(negedge clk);
        end
        model_sweep();
        check_all("timing");

        // Phase wrap across 0 / CYCLE-1
        phase[0] = 13'd4090;
        run_sweep();
        chk("ph_preload", 32'(pso[0]), 32'd4090);
        enable = 1'b1;
        step_p = 13'd8;
        phase[0] = 13'd5;
        run_sweep();
        chk("ph_wrap", 32'(pso[0]), WRAP ? 32'd2 : 32'd4082);

        // Two UPDATE pulses while busy -> one extra sweep
        step_d = 13'd3;
        step_p = 13'd2;
        for (int i = 0; i < D; i++) begin
            duty[i] = W'(500 + i);
            phase[i] = W'(40 * i + 1);
        end
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        npulse = 0;
        repeat (2) begin
            @(negedge clk);
            if (ov) npulse++;
        end
        update = 1'b1;
        @(negedge clk);
        if (ov) npulse++;
        update = 1'b0;
        @(negedge clk);
        if (ov) npulse++;
        update = 1'b1;
        @(negedge clk);
        if (ov) npulse++;
        update = 1'b0;
        begin
            int more;
            count_pulses(3 * (D + 6), more);
            npulse += more;
        end
        chk("pending_pulses", 32'(npulse), 32'd2);
        model_sweep();
        model_sweep();
        check_all("pending");

        // Bypass jumps straight to target
        enable = 1'b0;
        duty[1] = 13'd3000;
        run_sweep();
        chk("bypass_d1", 32'(dso[1]), 32'd3000);
        check_all("bypass");

        // Async reset mid-sweep discards sweep and pending
        enable = 1'b1;
        duty[1] = 13'd0;
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < D; i++) begin
            m_d[i] = 0;
            m_p[i] = 0;
        end
        check_all("midrst");
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ov", 32'(ov), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_pulses(2 * (D + 6), npulse);
        chk("midrst_no_pending", 32'(npulse), 32'd0);

        // Randomized sweeps with a fixed CYCLE map, one channel disabled by CYCLE=0
        do_reset();
        for (int i = 0; i < D; i++) cyc[i] = (i == D - 1) ? '0 : W'($urandom_range(2, 8191));
        for (int s = 0; s < 24; s++) begin
            enable = ($urandom_range(0, 3) != 0);
            step_d = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8191)) : W'($urandom_range(0, 300));
            step_p = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8191)) : W'($urandom_range(0, 300));
            for (int i = 0; i < D; i++) begin
                duty[i] = W'($urandom_range(0, 8191));
                phase[i] = (cyc[i] == 0) ? W'($urandom_range(0, 8191))
                                         : W'($urandom_range(0, int'(cyc[i]) - 1));
            end
            run_sweep();
            check_all($sformatf("rnd%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
